// File: rtl/serial_sub_controller_pkg.sv
// Shared types and helpers for the bit-serial subtractor: state encoding,
// default operand width and the one-bit full-subtractor equations.
package serial_sub_controller_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encoding 2'b11 is unused and steers the FSM back to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

  function automatic logic sub_diff(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  function automatic logic sub_borrow(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full-subtractor with its borrow flip-flop; the borrow only
// advances when EN is high and can be cleared synchronously via CLR.
module serial_sub_cell
  import serial_sub_controller_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  input  logic a,
  input  logic b,
  output logic d,
  output logic bq
);

  assign d = sub_diff(a, b, bq);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bq <= 1'b0;
    end else if (CLR) begin
      bq <= 1'b0;
    end else if (EN) begin
      bq <= sub_borrow(a, b, bq);
    end
  end

endmodule

// File: rtl/serial_sub_controller.sv
// Sequencer for the bit-serial subtractor: captures A/B, shifts them LSB-first
// through serial_sub_cell, and publishes DIFF/BORROW_OUT with a DONE pulse.
module serial_sub_controller
  import serial_sub_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW_OUT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             cell_clr;
  logic             cell_en;
  logic             cell_d;
  logic             cell_bq;
  logic             bnext;

  // The borrow is cleared on the accepting edge so every operation starts clean
  assign cell_clr = (state == ST_IDLE) && START;
  assign cell_en  = (state == ST_SHIFT);
  assign bnext    = sub_borrow(a_sr[0], b_sr[0], cell_bq);

  serial_sub_cell u_cell (
    .CLK (CLK),
    .RST (RST),
    .CLR (cell_clr),
    .EN  (cell_en),
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .d   (cell_d),
    .bq  (cell_bq)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      DIFF       <= '0;
      BORROW_OUT <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            a_sr   <= A;
            b_sr   <= B;
            res_sr <= '0;
            cnt    <= '0;
            BUSY   <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {cell_d, res_sr[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          // Outputs are only written here, so they never expose partial results
          if (cnt == LAST_BIT) begin
            DIFF       <= {cell_d, res_sr[WIDTH-1:1]};
            BORROW_OUT <= bnext;
            BUSY       <= 1'b0;
            DONE       <= 1'b1;
            state      <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          DONE  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
